// File: rtl/fp32_adder_arbiter_if.sv
// Requester, result and adder handshake bundle for fp32_adder_arbiter.
// master = arbiter side, slave = requesters plus the adder.
interface fp32_adder_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_STB;
  logic [NUM_REQ-1:0]    req_ACK;
  logic [31:0]           resp_sum;
  logic [NUM_REQ-1:0]    resp_STB;
  logic [NUM_REQ-1:0]    resp_BUSY;
  logic [31:0]           adder_a;
  logic [31:0]           adder_b;
  logic                  adder_input_STB;
  logic                  adder_BUSY;
  logic [31:0]           adder_sum;
  logic                  adder_output_STB;
  logic                  output_module_BUSY;

  modport master (
    input  req_a, req_b, req_STB, resp_BUSY, adder_BUSY, adder_sum, adder_output_STB,
    output req_ACK, resp_sum, resp_STB, adder_a, adder_b, adder_input_STB, output_module_BUSY
  );

  modport slave (
    output req_a, req_b, req_STB, resp_BUSY, adder_BUSY, adder_sum, adder_output_STB,
    input  req_ACK, resp_sum, resp_STB, adder_a, adder_b, adder_input_STB, output_module_BUSY
  );
endinterface

// File: rtl/fp32_adder_arbiter.sv
// Round-robin arbiter sharing one non-pipelined fp32 adder among NUM_REQ requesters.
// Define FP32_ARB_PERF_EN to build the perf_ops/perf_busy counters (tied to 0 otherwise).
module fp32_adder_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  fp32_adder_arbiter_if.master bus,
  output logic [31:0]        perf_ops,
  output logic [31:0]        perf_busy
);
  localparam int TAG_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

  state_t             r_state, w_state_nx;
  logic [TAG_W-1:0]   r_ptr, w_ptr_nx;
  logic [TAG_W-1:0]   r_tag, w_tag_nx;
  logic [31:0]        r_a, w_a_nx;
  logic [31:0]        r_b, w_b_nx;
  logic [31:0]        r_sum, w_sum_nx;
  logic [NUM_REQ-1:0] r_ack, w_ack_nx;
  logic [NUM_REQ-1:0] r_rstb, w_rstb_nx;
  logic               r_in_stb, w_in_stb_nx;
  logic               r_obusy, w_obusy_nx;

  logic               w_found;
  logic [TAG_W-1:0]   w_gnt;
  logic [31:0]        w_sel_a, w_sel_b;

  // Two passes give the wrap-around order ptr..NUM_REQ-1, then 0..ptr-1.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && (i >= int'(r_ptr)) && bus.req_STB[i]) begin
        w_found = 1'b1;
        w_gnt   = TAG_W'(i);
        w_sel_a = bus.req_a[32*i +: 32];
        w_sel_b = bus.req_b[32*i +: 32];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && (i < int'(r_ptr)) && bus.req_STB[i]) begin
        w_found = 1'b1;
        w_gnt   = TAG_W'(i);
        w_sel_a = bus.req_a[32*i +: 32];
        w_sel_b = bus.req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_ptr_nx    = r_ptr;
    w_tag_nx    = r_tag;
    w_a_nx      = r_a;
    w_b_nx      = r_b;
    w_sum_nx    = r_sum;
    w_ack_nx    = '0;
    w_rstb_nx   = r_rstb;
    w_in_stb_nx = r_in_stb;
    w_obusy_nx  = r_obusy;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_a_nx      = w_sel_a;
          w_b_nx      = w_sel_b;
          w_tag_nx    = w_gnt;
          w_ack_nx    = NUM_REQ'(1) << w_gnt;
          w_ptr_nx    = (int'(w_gnt) == NUM_REQ - 1) ? '0 : w_gnt + 1'b1;
          w_in_stb_nx = 1'b1;
          w_state_nx  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_in_stb && !bus.adder_BUSY) begin
          w_in_stb_nx = 1'b0;
          w_state_nx  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.adder_output_STB) begin
          w_sum_nx   = bus.adder_sum;
          w_rstb_nx  = NUM_REQ'(1) << r_tag;
          w_obusy_nx = 1'b1;
          w_state_nx = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if ((r_rstb & ~bus.resp_BUSY) != '0) begin
          w_rstb_nx  = '0;
          w_obusy_nx = 1'b0;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Reset abandons any in-flight operation; a late adder result is drained in IDLE/ISSUE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_tag    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_ack    <= '0;
      r_rstb   <= '0;
      r_in_stb <= 1'b0;
      r_obusy  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_ptr    <= w_ptr_nx;
      r_tag    <= w_tag_nx;
      r_a      <= w_a_nx;
      r_b      <= w_b_nx;
      r_sum    <= w_sum_nx;
      r_ack    <= w_ack_nx;
      r_rstb   <= w_rstb_nx;
      r_in_stb <= w_in_stb_nx;
      r_obusy  <= w_obusy_nx;
    end
  end

  assign bus.req_ACK            = r_ack;
  assign bus.resp_STB           = r_rstb;
  assign bus.resp_sum           = r_sum;
  assign bus.adder_a            = r_a;
  assign bus.adder_b            = r_b;
  assign bus.adder_input_STB    = r_in_stb;
  assign bus.output_module_BUSY = r_obusy;

`ifdef FP32_ARB_PERF_EN
  logic [31:0] r_perf_ops, r_perf_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_ops  <= '0;
      r_perf_busy <= '0;
    end else begin
      if (r_state == S_DELIVER && w_state_nx == S_IDLE) r_perf_ops <= r_perf_ops + 32'd1;
      if (r_state != S_IDLE) r_perf_busy <= r_perf_busy + 32'd1;
    end
  end

  assign perf_ops  = r_perf_ops;
  assign perf_busy = r_perf_busy;
`else
  assign perf_ops  = '0;
  assign perf_busy = '0;
`endif
endmodule

// File: doc/fp32_adder_arbiter.md
# fp32_adder_arbiter

Round-robin arbiter that shares one `adder_fp32` instance among `NUM_REQ` requesters, such as the PCPI co-processor path and DMA/accelerator ports. It accepts one request at a time, drives the adder's STB/BUSY input handshake and drains its output handshake. It then returns the sum to the originating requester on a shared result bus with a per-requester strobe. Only one operation is in flight at a time, because the adder is not pipelined.

## Interface
- `NUM_REQ`, 4, number of requesters, legal range 2..8.
- `TAG_W`, $clog2(NUM_REQ), width of the internal grant tag (derived; do not override).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_a`  in  32*NUM_REQ  operand A; slice i is [32*i+31:32*i].
- `req_b`  in  32*NUM_REQ  operand B, same slicing.
- `req_STB`  in  NUM_REQ  request valid; held until the matching `req_ACK` bit is seen.
- `req_ACK`  out  NUM_REQ  one-cycle pulse; request i was latched.
- `resp_sum`  out  32  result bus, shared; valid only while a `resp_STB` bit is high.
- `resp_STB`  out  NUM_REQ  result valid for requester i; at most one bit high.
- `resp_BUSY`  in  NUM_REQ  requester i cannot take its result.
- `adder_a`, `adder_b`  out  32  drive `input_a`/`input_b` of the adder.
- `adder_input_STB`  out  1  drives adder `adder_input_STB`.
- `adder_BUSY`  in  1  from adder `adder_BUSY`.
- `adder_sum`  in  32  from adder `output_sum`.
- `adder_output_STB`  in  1  from adder `adder_output_STB`.
- `output_module_BUSY`  out  1  drives adder `output_module_BUSY`.
- `perf_ops`  out  32  completed-operation count (see Configuration).
- `perf_busy`  out  32  cycles not in IDLE (see Configuration).

## Operation
- **States:** IDLE, ISSUE, WAIT, DELIVER.
- **IDLE**
  - Scan `req_STB` starting at `ptr` and wrapping: ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1.
  - On the first set bit i: latch `req_a`/`req_b` slice i into operand registers and set tag = i.
  - Pulse `req_ACK[i]` for one cycle, set `ptr` = (i+1) mod NUM_REQ, set `adder_input_STB`=1, go to ISSUE.
  - With no request pending, stay in IDLE; `ptr` is unchanged.
- **ISSUE**
  - `adder_a`/`adder_b` show the operand registers.
  - On an edge with `adder_input_STB`=1 and `adder_BUSY`=0 (the same edge on which the adder latches): clear `adder_input_STB`, go to WAIT.
- **WAIT**
  - On an edge with `adder_output_STB`=1: capture `adder_sum` into `resp_sum` and set `resp_STB[tag]`=1.
  - Set `output_module_BUSY`=1 and go to DELIVER.
- **DELIVER**
  - `resp_STB[tag]` and `resp_sum` are held stable.
  - On an edge with `resp_STB[tag]`=1 and `resp_BUSY[tag]`=0: clear `resp_STB`, set `output_module_BUSY`=0, go to IDLE.
- **`output_module_BUSY`:** 1 only in DELIVER.
  - In IDLE and ISSUE, any `adder_output_STB` is a stray result left over from an arbiter reset. It is drained and discarded: it does not update `resp_sum` and asserts no `resp_STB`.
  - A stalled ISSUE therefore always resolves once the adder returns to its input state.
- **Requesters:** must not change their `req_a`/`req_b` slice while `req_STB` is high and unacknowledged. They must drop `req_STB` in the cycle `req_ACK` is seen, otherwise they are re-arbitrated after DELIVER.
- **Reset (`rst`=0, asynchronous)**
  - State IDLE, `ptr`=0.
  - All outputs are 0: `req_ACK`, `resp_STB`, `resp_sum`, `adder_a`, `adder_b`, `adder_input_STB`, `output_module_BUSY`, `perf_*`.
  - Reset mid-operation abandons the in-flight request; no `resp_STB` is ever asserted for it.

## Timing
- Request sampled at edge E0. `req_ACK` and `adder_input_STB` are high in the cycle after E0.
- Adder hand-off is at E1 at the earliest (1 cycle in ISSUE when the adder is idle).
- `resp_STB` rises on the edge after the adder's first PUT_Z cycle.
- Minimum overhead beyond adder latency: 1 cycle (IDLE) + 1 (ISSUE) + 1 (DELIVER). A new grant is possible on the edge after DELIVER exits.
- Requests arriving while not in IDLE wait; there is no queueing beyond the requester's own STB.
- `resp_BUSY` may be held high indefinitely; the arbiter and adder both stall, and no other requester is served.

## Configuration
- **`FP32_ARB_PERF_EN` defined**
  - `perf_ops` increments by 1 on each DELIVER exit.
  - `perf_busy` increments on every cycle with state ≠ IDLE.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by `rst`.
- **`FP32_ARB_PERF_EN` undefined:** counters are not built; `perf_ops` and `perf_busy` are tied to 0.

## Test plan
- **Single request:** requester 1 with a=0x3F800000 (1.0), b=0x40000000 (2.0) → `req_ACK[1]` pulse, then `resp_STB[1]` with `resp_sum`=0x40400000; `ptr`=2 afterwards.
- **Fairness:** all four `req_STB` held continuously from reset → grants in order 0,1,2,3,0,…; each requester gets exactly one grant per four operations.
- **Back-pressure:** `resp_BUSY[2]`=1 for 5 cycles after `resp_STB[2]` rises (operands 0xC0A00000 + 0x40A00000) → `resp_STB[2]` held and `resp_sum`=0x00000000 stable; clears one edge after `resp_BUSY[2]` falls; `output_module_BUSY`=1 throughout.
- **Reset in WAIT:** pulse `rst` low while the adder computes 0x3F800000 + 0x3F800000; the adder is not reset.
  - → All outputs 0; the adder's stray result is drained with no `resp_STB`.
  - A following request 0x40000000 + 0x40000000 returns 0x40800000.
- **Special value:** a=0x7F800000, b=0xFF800000 → `resp_sum`=0xFFC00000 delivered to the granted requester only.
- **Counters (`FP32_ARB_PERF_EN` defined):** 3 completed operations → `perf_ops`=3 and `perf_busy` equals the measured non-IDLE cycle count; with the macro undefined, both read 0.
